// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared opcodes, functional-unit classes and scoreboard entry type for the hazard scoreboard
package sb_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Countdown storage width; MAX_LAT must stay below 2**SB_CNT_W.
    localparam int SB_CNT_W = 4;
    localparam int SB_IDX_W = 5;

    typedef logic [SB_IDX_W-1:0] reg_idx_t;

    typedef enum logic [2:0] {
        FU_NONE,
        FU_UJ,
        FU_R,
        FU_BS,
        FU_I
    } fu_class_e;

    typedef struct packed {
        logic                pending;
        logic [SB_CNT_W-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/sb_opcode_decode.sv
// rtl/sb_opcode_decode.sv - maps an opcode to its register-usage class
module sb_opcode_decode
    import sb_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       writes_rd
);

    fu_class_e fu_class;

    always_comb begin
        fu_class = FU_NONE;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL:    fu_class = FU_UJ;
            OP_R:                        fu_class = FU_R;
            OP_BRANCH, OP_STORE:         fu_class = FU_BS;
            OP_IMM, OP_LOAD, OP_JALR:    fu_class = FU_I;
            default:                     fu_class = FU_NONE;
        endcase
    end

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (fu_class)
            FU_UJ: writes_rd = 1'b1;
            FU_R: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            FU_BS: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            FU_I: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard_p.sv
// rtl/hazard_scoreboard_p.sv - register-hazard scoreboard with branch kill window; SB_BYPASS_EN enables forwarding of final-cycle results
module hazard_scoreboard_p
    import sb_pkg::*;
#(
    parameter int NREGS        = 32,
    parameter int MAX_LAT      = 3,
    parameter int KILL_CYCLES  = 2,
    parameter int SQUASH_DEPTH = 1
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         issue_valid,
    input  logic [6:0]                   opcode,
    input  logic [$clog2(NREGS)-1:0]     rs1,
    input  logic [$clog2(NREGS)-1:0]     rs2,
    input  logic [$clog2(NREGS)-1:0]     rd,
    input  logic                         br_taken,
    input  logic                         br_link,
    input  logic [$clog2(NREGS)-1:0]     br_link_rd,
    output logic                         stall,
    output logic                         kill,
    output logic [$clog2(MAX_LAT+1)-1:0] stall_cnt,
    output logic [NREGS-1:0]             busy_vec
);

    localparam int IW = $clog2(NREGS);
    localparam int CW = $clog2(MAX_LAT+1);
    localparam int KW = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;

    localparam logic [SB_CNT_W-1:0] LAT_C = SB_CNT_W'(MAX_LAT);
    localparam logic [SB_CNT_W-1:0] SQ_THR = SB_CNT_W'(MAX_LAT - SQUASH_DEPTH);
    localparam logic [KW-1:0]       KILL_RELOAD = KW'(KILL_CYCLES - 1);

    logic uses_rs1, uses_rs2, writes_rd;

    sb_opcode_decode u_decode (
        .opcode    (opcode),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd)
    );

    sb_entry_t           ent [NREGS];
    logic [KW-1:0]       kcnt;
    logic                hz1, hz2, alloc;
    logic [SB_CNT_W-1:0] c1, c2, cmax;

    // A result in its last countdown cycle is forwarded, so it no longer blocks.
    function automatic logic src_hazard(input sb_entry_t e);
`ifdef SB_BYPASS_EN
        return e.pending && (e.cnt != SB_CNT_W'(1));
`else
        return e.pending;
`endif
    endfunction

    always_comb begin
        hz1   = uses_rs1 && (rs1 != '0) && src_hazard(ent[rs1]);
        hz2   = uses_rs2 && (rs2 != '0) && src_hazard(ent[rs2]);
        kill  = br_taken || (kcnt != '0);
        stall = issue_valid && !kill && (hz1 || hz2);
        c1    = hz1 ? ent[rs1].cnt : '0;
        c2    = hz2 ? ent[rs2].cnt : '0;
        cmax  = (c1 > c2) ? c1 : c2;
        stall_cnt = stall ? cmax[CW-1:0] : '0;
        alloc = issue_valid && !stall && !kill && writes_rd && (rd != '0);
        for (int i = 0; i < NREGS; i++) begin
            busy_vec[i] = ent[i].pending;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            kcnt <= '0;
            for (int i = 0; i < NREGS; i++) begin
                ent[i] <= '0;
            end
        end else begin
            if (br_taken) begin
                kcnt <= KILL_RELOAD;
            end else if (kcnt != '0) begin
                kcnt <= kcnt - KW'(1);
            end

            ent[0] <= '0;
            // Priority per entry: allocation, then branch squash, then countdown.
            for (int i = 1; i < NREGS; i++) begin
                if (alloc && (rd == IW'(i))) begin
                    ent[i].pending <= 1'b1;
                    ent[i].cnt     <= LAT_C;
                end else if (br_taken && ent[i].pending && (ent[i].cnt > SQ_THR)
                             && !(br_link && (br_link_rd == IW'(i)))) begin
                    ent[i] <= '0;
                end else if (ent[i].pending) begin
                    ent[i].cnt <= ent[i].cnt - SB_CNT_W'(1);
                    if (ent[i].cnt == SB_CNT_W'(1)) begin
                        ent[i].pending <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
